reg_file: RTL

//  Architectural register file with rename (dependency) tags; directly downstream of the ROB commit port.

---
 rtl/reg_file_pkg.sv | 18 +
 rtl/reg_file_if.sv | 37 +++
 rtl/reg_file_read_port.sv | 32 +++
 rtl/reg_file.sv | 100 ++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared widths, types and the tag-match helper for the rename-tagged register file.
package reg_file_pkg;

    localparam int XLEN           = 32;
    localparam int REG_NUM        = 32;
    localparam int REG_NUM_WIDTH  = 5;
    localparam int ROB_SIZE_WIDTH = 5;

    typedef logic [XLEN-1:0]           data_t;
    typedef logic [REG_NUM_WIDTH-1:0]  reg_idx_t;
    typedef logic [ROB_SIZE_WIDTH-1:0] rob_id_t;

    // A commit only retires a register whose live rename still names that ROB entry.
    function automatic logic tag_match(input logic busy, input rob_id_t tag, input rob_id_t rob_id);
        return busy && (tag == rob_id);
    endfunction

endpackage

// File: rtl/reg_file_if.sv
// Decoder rename/read and ROB commit signals between the pipeline and the register file.
interface reg_file_if;
    import reg_file_pkg::*;

    logic     dec_rename_valid;
    reg_idx_t dec_rename_rd;
    rob_id_t  dec_rename_rob_id;
    reg_idx_t dec_rs1;
    reg_idx_t dec_rs2;

    logic     rob2rf_ready;
    reg_idx_t rob2rf_rd;
    data_t    rob2rf_value;
    rob_id_t  rob2rf_rob_id;

    logic     rf2dec_has_dep1;
    rob_id_t  rf2dec_dep1;
    data_t    rf2dec_val1;
    logic     rf2dec_has_dep2;
    rob_id_t  rf2dec_dep2;
    data_t    rf2dec_val2;

    modport master (
        output dec_rename_valid, dec_rename_rd, dec_rename_rob_id, dec_rs1, dec_rs2,
        output rob2rf_ready, rob2rf_rd, rob2rf_value, rob2rf_rob_id,
        input  rf2dec_has_dep1, rf2dec_dep1, rf2dec_val1,
        input  rf2dec_has_dep2, rf2dec_dep2, rf2dec_val2
    );

    modport slave (
        input  dec_rename_valid, dec_rename_rd, dec_rename_rob_id, dec_rs1, dec_rs2,
        input  rob2rf_ready, rob2rf_rd, rob2rf_value, rob2rf_rob_id,
        output rf2dec_has_dep1, rf2dec_dep1, rf2dec_val1,
        output rf2dec_has_dep2, rf2dec_dep2, rf2dec_val2
    );

endinterface

// File: rtl/reg_file_read_port.sv
// One combinational source-operand lookup: x0, then same-cycle commit bypass, then rename tag, then value.
module reg_file_read_port
    import reg_file_pkg::*;
(
    input  reg_idx_t rs,
    input  data_t    rs_val,
    input  logic     rs_busy,
    input  rob_id_t  rs_tag,
    input  logic     commit_ready,
    input  reg_idx_t commit_rd,
    input  rob_id_t  commit_rob_id,
    input  data_t    commit_value,
    output logic     has_dep,
    output rob_id_t  dep,
    output data_t    val
);

    always_comb begin
        has_dep = 1'b0;
        dep     = '0;
        val     = rs_val;
        if (rs == '0) begin
            val = '0;
        end else if (commit_ready && (commit_rd == rs) && tag_match(rs_busy, rs_tag, commit_rob_id)) begin
            val = commit_value;
        end else if (rs_busy) begin
            has_dep = 1'b1;
            dep     = rs_tag;
        end
    end

endmodule

// File: rtl/reg_file.sv
// Architectural register file with per-register ROB rename tags, commit writeback and flush.
module reg_file
    import reg_file_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic        need_flush_in,
    reg_file_if.slave   bus
);

    data_t   reg_val  [REG_NUM];
    logic    reg_busy [REG_NUM];
    rob_id_t reg_tag  [REG_NUM];

    genvar gi;
    generate
        for (gi = 0; gi < REG_NUM; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign reg_val[gi]  = '0;
                assign reg_busy[gi] = 1'b0;
                assign reg_tag[gi]  = '0;
            end else begin : g_arch
                data_t   val_q, val_d;
                logic    busy_q, busy_d;
                rob_id_t tag_q, tag_d;
                logic    commit_hit, rename_hit;

                assign commit_hit = bus.rob2rf_ready && (bus.rob2rf_rd == reg_idx_t'(gi));
                assign rename_hit = bus.dec_rename_valid && (bus.dec_rename_rd == reg_idx_t'(gi));

                // Rename is applied after the commit clear so a same-cycle rename keeps the register busy.
                always_comb begin
                    val_d  = val_q;
                    busy_d = busy_q;
                    tag_d  = tag_q;
                    if (rdy_in) begin
                        if (commit_hit) begin
                            val_d = bus.rob2rf_value;
                            if (tag_match(busy_q, tag_q, bus.rob2rf_rob_id)) begin
                                busy_d = 1'b0;
                            end
                        end
                        if (need_flush_in) begin
                            busy_d = 1'b0;
                        end else if (rename_hit) begin
                            busy_d = 1'b1;
                            tag_d  = bus.dec_rename_rob_id;
                        end
                    end
                end

                always_ff @(posedge clk_in or negedge rst_n_in) begin
                    if (!rst_n_in) begin
                        val_q  <= '0;
                        busy_q <= 1'b0;
                        tag_q  <= '0;
                    end else begin
                        val_q  <= val_d;
                        busy_q <= busy_d;
                        tag_q  <= tag_d;
                    end
                end

                assign reg_val[gi]  = val_q;
                assign reg_busy[gi] = busy_q;
                assign reg_tag[gi]  = tag_q;
            end
        end
    endgenerate

    reg_file_read_port u_read_rs1 (
        .rs            (bus.dec_rs1),
        .rs_val        (reg_val[bus.dec_rs1]),
        .rs_busy       (reg_busy[bus.dec_rs1]),
        .rs_tag        (reg_tag[bus.dec_rs1]),
        .commit_ready  (bus.rob2rf_ready),
        .commit_rd     (bus.rob2rf_rd),
        .commit_rob_id (bus.rob2rf_rob_id),
        .commit_value  (bus.rob2rf_value),
        .has_dep       (bus.rf2dec_has_dep1),
        .dep           (bus.rf2dec_dep1),
        .val           (bus.rf2dec_val1)
    );

    reg_file_read_port u_read_rs2 (
        .rs            (bus.dec_rs2),
        .rs_val        (reg_val[bus.dec_rs2]),
        .rs_busy       (reg_busy[bus.dec_rs2]),
        .rs_tag        (reg_tag[bus.dec_rs2]),
        .commit_ready  (bus.rob2rf_ready),
        .commit_rd     (bus.rob2rf_rd),
        .commit_rob_id (bus.rob2rf_rob_id),
        .commit_value  (bus.rob2rf_value),
        .has_dep       (bus.rf2dec_has_dep2),
        .dep           (bus.rf2dec_dep2),
        .val           (bus.rf2dec_val2)
    );

endmodule
